// File: rtl/cache_pkg.sv
// Shared state encoding, default geometry and line metadata layout for the
// direct-mapped write-back cache controller.
package cache_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DEPTH          = 32;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_TAG_W          = DEF_ADDR_W - $clog2(DEF_DEPTH)
                                        - ($clog2(DEF_WORDS_PER_LINE) + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WRITE_BACK,
        ST_ALLOCATE
    } cache_state_e;

    // Line metadata at the default geometry; other geometries keep the same field order.
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [DEF_TAG_W-1:0] tag;
    } cache_tag_type;

endpackage

// File: rtl/dm_cache_array.sv
// Tag/data storage for the direct-mapped cache: one asynchronous read port and
// one write port that either merges bytes into a word or replaces a whole line.
module dm_cache_array
    import cache_pkg::*;
#(
    parameter int  DEPTH          = DEF_DEPTH,
    parameter int  WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int  TAG_W          = DEF_TAG_W,
    localparam int LINE_W         = 32 * WORDS_PER_LINE,
    localparam int INDEX_W        = $clog2(DEPTH),
    localparam int WSEL_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [LINE_W-1:0]  rd_line_o,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic               word_we_i,
    input  logic [WSEL_W-1:0]  word_sel_i,
    input  logic [3:0]         word_be_i,
    input  logic [31:0]        word_data_i,
    input  logic               fill_we_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [LINE_W-1:0]  fill_line_i
);

    logic [LINE_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  dirty_q;
    logic [LINE_W-1:0] merged_line;

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

    always_comb begin
        merged_line = data_q[wr_index_i];
        for (int b = 0; b < 4; b++) begin
            if (word_be_i[b]) begin
                merged_line[32*int'(word_sel_i) + 8*b +: 8] = word_data_i[8*b +: 8];
            end
        end
    end

    // Payload arrays carry no reset; only the valid/dirty bits define cache contents.
    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            data_q[wr_index_i] <= fill_line_i;
            tag_q[wr_index_i]  <= fill_tag_i;
        end else if (word_we_i) begin
            data_q[wr_index_i] <= merged_line;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[wr_index_i] <= 1'b1;
            dirty_q[wr_index_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[wr_index_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller (FSM + datapath).
// Optional hit/miss counters are enabled by defining DM_CACHE_STATS_EN.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int  ADDR_W         = DEF_ADDR_W,
    parameter int  DEPTH          = DEF_DEPTH,
    parameter int  WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    localparam int LINE_W         = 32 * WORDS_PER_LINE,
    localparam int OFFSET_W       = $clog2(WORDS_PER_LINE) + 2,
    localparam int INDEX_W        = $clog2(DEPTH),
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W,
    localparam int WSEL_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ADDR_W-1:0]  cpu_addr_i,
    input  logic [31:0]        cpu_wdata_i,
    input  logic [3:0]         cpu_be_i,
    input  logic               cpu_rw_i,
    input  logic               cpu_valid_i,
    output logic [31:0]        cpu_rdata_o,
    output logic               cpu_ready_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [LINE_W-1:0]  mem_wdata_o,
    output logic               mem_rw_o,
    output logic               mem_valid_o,
    input  logic [LINE_W-1:0]  mem_rdata_i,
    input  logic               mem_ready_i,
    output cache_state_e       dbg_state_o
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o
`endif
);

    // CPU side: a request is taken in IDLE when cpu_valid_i is high; cpu_ready_o
    // is a single-cycle completion pulse. Memory side: mem_valid_o and its payload
    // hold until mem_ready_i is sampled high, which completes that transfer.
    cache_state_e      state_q, state_d;
    logic [ADDR_W-1:2] req_addr_q;
    logic [31:0]       req_wdata_q;
    logic [3:0]        req_be_q;
    logic              req_rw_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic               req_latch, cpu_ready, word_we, fill_we, hit;
    logic [TAG_W-1:0]   req_tag, rd_tag;
    logic [INDEX_W-1:0] req_index;
    logic [WSEL_W-1:0]  word_sel;
    logic               rd_valid, rd_dirty;
    logic [LINE_W-1:0]  rd_line;
    logic [31:0]        hit_word;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_index = req_addr_q[OFFSET_W +: INDEX_W];

    if (WORDS_PER_LINE > 1) begin : g_word_sel
        assign word_sel = req_addr_q[OFFSET_W-1:2];
    end else begin : g_single_word
        assign word_sel = 1'b0;
    end

    dm_cache_array #(
        .DEPTH          (DEPTH),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_index_i  (req_index),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_tag_o    (rd_tag),
        .rd_line_o   (rd_line),
        .wr_index_i  (req_index),
        .word_we_i   (word_we),
        .word_sel_i  (word_sel),
        .word_be_i   (req_be_q),
        .word_data_i (req_wdata_q),
        .fill_we_i   (fill_we),
        .fill_tag_i  (req_tag),
        .fill_line_i (mem_rdata_i)
    );

    assign hit      = rd_valid && (rd_tag == req_tag);
    assign hit_word = rd_line[32*int'(word_sel) +: 32];

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        mem_valid_d = mem_valid_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        req_latch   = 1'b0;
        cpu_ready   = 1'b0;
        word_we     = 1'b0;
        fill_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_valid_i) begin
                    req_latch = 1'b1;
                    state_d   = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    state_d   = ST_IDLE;
                    if (req_rw_q) begin
                        word_we = 1'b1;
                    end else begin
                        rdata_d = hit_word;
                    end
                end else if (rd_valid && rd_dirty) begin
                    state_d     = ST_WRITE_BACK;
                    mem_valid_d = 1'b1;
                    mem_rw_d    = 1'b1;
                    mem_addr_d  = {rd_tag, req_index, {OFFSET_W{1'b0}}};
                    mem_wdata_d = rd_line;
                end else begin
                    state_d     = ST_ALLOCATE;
                    mem_valid_d = 1'b1;
                    mem_rw_d    = 1'b0;
                    mem_addr_d  = {req_tag, req_index, {OFFSET_W{1'b0}}};
                end
            end
            ST_WRITE_BACK: begin
                // The fill request follows the eviction without a gap in mem_valid_o.
                if (mem_valid_q && mem_ready_i) begin
                    state_d    = ST_ALLOCATE;
                    mem_rw_d   = 1'b0;
                    mem_addr_d = {req_tag, req_index, {OFFSET_W{1'b0}}};
                end
            end
            ST_ALLOCATE: begin
                if (mem_valid_q && mem_ready_i) begin
                    fill_we     = 1'b1;
                    mem_valid_d = 1'b0;
                    state_d     = ST_COMPARE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            req_rw_q    <= 1'b0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (req_latch) begin
                req_addr_q  <= cpu_addr_i[ADDR_W-1:2];
                req_wdata_q <= cpu_wdata_i;
                req_be_q    <= cpu_be_i;
                req_rw_q    <= cpu_rw_i;
            end
        end
    end

    // Read data is forwarded in the hit cycle and held afterwards.
    assign cpu_rdata_o = (state_q == ST_COMPARE && hit && !req_rw_q) ? hit_word : rdata_q;
    assign cpu_ready_o = cpu_ready;
    assign mem_valid_o = mem_valid_q;
    assign mem_rw_o    = mem_rw_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign dbg_state_o = state_q;

`ifdef DM_CACHE_STATS_EN
    logic        first_cmp_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Only the first COMPARE of a request counts; the re-check after a fill does not.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            first_cmp_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else if (req_latch) begin
            first_cmp_q <= 1'b1;
        end else if (state_q == ST_COMPARE) begin
            first_cmp_q <= 1'b0;
            if (first_cmp_q) begin
                if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
                else     miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed scenarios plus random traffic checked
// against a word-level golden memory and a per-index tag tracker.
module tb_dm_cache_ctrl;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]   cpu_be = '0;
    logic         cpu_rw = 1'b0, cpu_valid = 1'b0;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_ready_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic         mem_rw_o, mem_valid_o;
    logic [127:0] mem_rdata_i = '0;
    logic         mem_ready_i = 1'b0;
    cache_state_e dbg_state_o;
`ifdef DM_CACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_be_i(cpu_be),
        .cpu_rw_i(cpu_rw), .cpu_valid_i(cpu_valid),
        .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rw_o(mem_rw_o),
        .mem_valid_o(mem_valid_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .dbg_state_o(dbg_state_o)
`ifdef DM_CACHE_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [127:0] backing [int unsigned];   // main memory, keyed by line address >> 4
    logic [31:0]  gold    [int unsigned];   // architecturally visible words, keyed by addr >> 2
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [22:0]  m_tag   [32];
    int           model_hits = 0, model_misses = 0;

    function automatic logic [127:0] backing_line(input int unsigned la);
        if (!backing.exists(la)) backing[la] = {$urandom, $urandom, $urandom, $urandom};
        return backing[la];
    endfunction

    function automatic logic [31:0] gold_word(input int unsigned wa);
        logic [127:0] line;
        if (gold.exists(wa)) return gold[wa];
        line = backing_line(wa >> 2);
        return line[32*(wa & 3) +: 32];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        gold.delete();
        model_hits = 0;
        model_misses = 0;
    endtask

    task automatic model_access(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                                input logic [3:0] be, output bit e_hit, output bit e_wb,
                                output logic [31:0] e_wb_addr, output logic [127:0] e_wb_line,
                                output logic [31:0] e_fill_addr, output logic [31:0] e_rdata);
        int idx;
        int unsigned wa;
        logic [31:0] w;
        idx = int'(addr[8:4]);
        wa = addr >> 2;
        e_hit = m_valid[idx] && (m_tag[idx] == addr[31:9]);
        e_wb = !e_hit && m_valid[idx] && m_dirty[idx];
        e_wb_addr = '0;
        e_wb_line = '0;
        if (e_wb) begin
            e_wb_addr = {m_tag[idx], addr[8:4], 4'h0};
            for (int k = 0; k < 4; k++) e_wb_line[32*k +: 32] = gold_word((e_wb_addr >> 2) + k);
        end
        e_fill_addr = {addr[31:4], 4'h0};
        if (e_hit) model_hits++;
        else model_misses++;
        if (!e_hit) begin
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx] = addr[31:9];
        end
        w = gold_word(wa);
        e_rdata = w;
        if (rw) begin
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            gold[wa] = w;
            m_dirty[idx] = 1'b1;
        end
    endtask

    // ---------------- driver + memory responder ----------------
    logic [31:0]  obs_addr_q [$];
    logic         obs_rw_q [$];
    logic [127:0] obs_wdata_q [$];
    int           obs_cycles, obs_unstable;
    bit           obs_timeout;
    logic [31:0]  obs_rdata, obs_prev_rdata;
    logic         obs_prev_ready;

    task automatic do_req(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                          input logic [3:0] be, input int d_wb, input int d_fill, input bit stray);
        int cyc, wait_cnt, delay;
        bit in_txn, done;
        logic [31:0] cur_addr;
        logic cur_rw;
        logic [127:0] cur_wdata;
        obs_addr_q.delete(); obs_rw_q.delete(); obs_wdata_q.delete();
        obs_unstable = 0; obs_timeout = 0; obs_cycles = 0; obs_rdata = 'x;
        cur_addr = '0; cur_rw = 1'b0; cur_wdata = '0;
        @(negedge clk);
        obs_prev_ready = cpu_ready_o;
        obs_prev_rdata = cpu_rdata_o;
        cpu_addr = addr; cpu_rw = rw; cpu_wdata = wdata; cpu_be = be; cpu_valid = 1'b1;
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        cpu_addr = $urandom; cpu_wdata = $urandom; cpu_be = 4'($urandom); cpu_rw = 1'($urandom);
        cyc = 0; wait_cnt = 0; delay = 0; in_txn = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready_o) begin
                obs_rdata = cpu_rdata_o;
                obs_cycles = cyc;
                done = 1'b1;
                if (in_txn || mem_valid_o) obs_unstable++;
            end else if (mem_valid_o) begin
                if (!in_txn) begin
                    cur_addr = mem_addr_o; cur_rw = mem_rw_o; cur_wdata = mem_wdata_o;
                    obs_addr_q.push_back(cur_addr);
                    obs_rw_q.push_back(cur_rw);
                    obs_wdata_q.push_back(cur_wdata);
                    in_txn = 1'b1;
                    wait_cnt = 0;
                    delay = cur_rw ? d_wb : d_fill;
                end else if (mem_addr_o !== cur_addr || mem_rw_o !== cur_rw || mem_wdata_o !== cur_wdata) begin
                    obs_unstable++;
                end
                if (wait_cnt == delay) begin
                    mem_ready_i = 1'b1;
                    if (cur_rw) backing[cur_addr >> 4] = mem_wdata_o;
                    else mem_rdata_i = backing_line(cur_addr >> 4);
                    @(posedge clk); #1;
                    mem_ready_i = 1'b0;
                    mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
                    in_txn = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                if (in_txn) obs_unstable++;
                in_txn = 1'b0;
                if (stray) begin
                    mem_ready_i = 1'b1;
                    @(posedge clk); #1;
                    mem_ready_i = 1'b0;
                end
            end
            if (!done && cyc >= 100) begin
                obs_timeout = 1'b1;
                done = 1'b1;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cpu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got=%b exp=0", cpu_ready_o); end
        checks++; if (cpu_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got=%h exp=0", cpu_rdata_o); end
        checks++; if (mem_valid_o !== 1'b0 || mem_rw_o !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl got=%b%b exp=00", mem_valid_o, mem_rw_o); end
        checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 128'h0) begin errors++; $display("FAIL reset_mem_bus addr=%h wdata=%h exp=0", mem_addr_o, mem_wdata_o); end
        checks++; if (dbg_state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state_o, ST_IDLE); end
`ifdef DM_CACHE_STATS_EN
        checks++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_stats hit=%0d miss=%0d exp=0/0", hit_cnt_o, miss_cnt_o); end
`endif
        rst_i = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (mem_valid_o !== 1'b0 || cpu_ready_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle valid=%b ready=%b exp=0/0", mem_valid_o, cpu_ready_o); end
    endtask

    task automatic test_cold_miss_hit();
        bit h, wb; logic [31:0] wa, fa, rd; logic [127:0] wl; int df;
        backing[1] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        df = $urandom_range(0, 3);
        model_access(32'h10, 1'b0, 32'h0, 4'h0, h, wb, wa, wl, fa, rd);
        do_req(32'h10, 1'b0, 32'h0, 4'h0, 0, df, 1'b0);
        checks++; if (obs_addr_q.size() != 1) begin errors++; $display("FAIL cold_txn_count got=%0d exp=1", obs_addr_q.size()); end
        else begin
            checks++; if (obs_addr_q[0] !== 32'h10 || obs_rw_q[0] !== 1'b0) begin errors++; $display("FAIL cold_fill_req addr=%h rw=%b exp=00000010/0", obs_addr_q[0], obs_rw_q[0]); end
        end
        checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL cold_rdata got=%h exp=00000000", obs_rdata); end
        checks++; if (obs_cycles != 3 + df) begin errors++; $display("FAIL cold_latency got=%0d exp=%0d", obs_cycles, 3 + df); end
        model_access(32'h14, 1'b0, 32'h0, 4'h0, h, wb, wa, wl, fa, rd);
        do_req(32'h14, 1'b0, 32'h0, 4'h0, 0, 0, 1'b1);
        checks++; if (obs_prev_ready !== 1'b0) begin errors++; $display("FAIL ready_pulse_width got=%b exp=0", obs_prev_ready); end
        checks++; if (obs_rdata !== 32'h11111111) begin errors++; $display("FAIL hit_rdata got=%h exp=11111111", obs_rdata); end
        checks++; if (obs_cycles != 1 || obs_addr_q.size() != 0) begin errors++; $display("FAIL hit_latency cycles=%0d txns=%0d exp=1/0", obs_cycles, obs_addr_q.size()); end
    endtask

    task automatic test_write_hit();
        bit h, wb; logic [31:0] wa, fa, rd; logic [127:0] wl;
        model_access(32'h14, 1'b1, 32'hAAAABBBB, 4'b0011, h, wb, wa, wl, fa, rd);
        do_req(32'h14, 1'b1, 32'hAAAABBBB, 4'b0011, 0, 0, 1'b0);
        checks++; if (obs_cycles != 1 || obs_addr_q.size() != 0) begin errors++; $display("FAIL write_hit cycles=%0d txns=%0d exp=1/0", obs_cycles, obs_addr_q.size()); end
        model_access(32'h14, 1'b0, 32'h0, 4'h0, h, wb, wa, wl, fa, rd);
        do_req(32'h14, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0);
        checks++; if (obs_rdata !== 32'h1111BBBB) begin errors++; $display("FAIL be_merge_rdata got=%h exp=1111bbbb", obs_rdata); end
        checks++; if (obs_addr_q.size() != 0) begin errors++; $display("FAIL be_merge_traffic got=%0d exp=0", obs_addr_q.size()); end
    endtask

    task automatic test_dirty_evict();
        bit h, wb; logic [31:0] wa, fa, rd; logic [127:0] wl; int dw, df;
        dw = $urandom_range(0, 3);
        df = $urandom_range(0, 3);
        model_access(32'h210, 1'b0, 32'h0, 4'h0, h, wb, wa, wl, fa, rd);
        do_req(32'h210, 1'b0, 32'h0, 4'h0, dw, df, 1'b0);
        checks++; if (obs_addr_q.size() != 2) begin errors++; $display("FAIL evict_txn_count got=%0d exp=2", obs_addr_q.size()); end
        else begin
            checks++; if (obs_addr_q[0] !== 32'h10 || obs_rw_q[0] !== 1'b1) begin errors++; $display("FAIL evict_wb_req addr=%h rw=%b exp=00000010/1", obs_addr_q[0], obs_rw_q[0]); end
            checks++; if (obs_wdata_q[0] !== {32'h33333333, 32'h22222222, 32'h1111BBBB, 32'h00000000}) begin errors++; $display("FAIL evict_wb_data got=%h", obs_wdata_q[0]); end
            checks++; if (obs_addr_q[1] !== 32'h210 || obs_rw_q[1] !== 1'b0) begin errors++; $display("FAIL evict_fill_req addr=%h rw=%b exp=00000210/0", obs_addr_q[1], obs_rw_q[1]); end
        end
        checks++; if (obs_rdata !== rd) begin errors++; $display("FAIL evict_rdata got=%h exp=%h", obs_rdata, rd); end
        checks++; if (obs_cycles != 4 + dw + df) begin errors++; $display("FAIL evict_latency got=%0d exp=%0d", obs_cycles, 4 + dw + df); end
`ifdef DM_CACHE_STATS_EN
        checks++; if (hit_cnt_o !== 32'd3 || miss_cnt_o !== 32'd2) begin errors++; $display("FAIL stats_scen hit=%0d miss=%0d exp=3/2", hit_cnt_o, miss_cnt_o); end
`endif
    endtask

    task automatic test_back_to_back();
        bit h, wb; logic [31:0] wa, fa, rd, prev; logic [127:0] wl; logic [31:0] a;
        prev = 'x;
        for (int k = 0; k < 4; k++) begin
            a = 32'h210 + 32'(4 * k);
            model_access(a, 1'b0, 32'h0, 4'h0, h, wb, wa, wl, fa, rd);
            do_req(a, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0);
            checks++; if (obs_rdata !== rd || obs_cycles != 1) begin errors++; $display("FAIL b2b_hit k=%0d rdata=%h exp=%h cycles=%0d", k, obs_rdata, rd, obs_cycles); end
            if (k > 0) begin
                checks++; if (obs_prev_ready !== 1'b0 || obs_prev_rdata !== prev) begin errors++; $display("FAIL b2b_hold k=%0d ready=%b rdata=%h exp=0/%h", k, obs_prev_ready, obs_prev_rdata, prev); end
            end
            prev = rd;
        end
    endtask

    task automatic test_slow_mem();
        bit h, wb; logic [31:0] wa, fa, rd; logic [127:0] wl;
        model_access(32'h1030, 1'b0, 32'h0, 4'h0, h, wb, wa, wl, fa, rd);
        do_req(32'h1030, 1'b0, 32'h0, 4'h0, 0, 5, 1'b0);
        checks++; if (obs_unstable != 0 || obs_cycles != 8) begin errors++; $display("FAIL slow_fill unstable=%0d cycles=%0d exp=0/8", obs_unstable, obs_cycles); end
        checks++; if (obs_rdata !== rd) begin errors++; $display("FAIL slow_fill_rdata got=%h exp=%h", obs_rdata, rd); end
        model_access(32'h1034, 1'b1, 32'h5A5A5A5A, 4'hF, h, wb, wa, wl, fa, rd);
        do_req(32'h1034, 1'b1, 32'h5A5A5A5A, 4'hF, 0, 0, 1'b0);
        model_access(32'h3030, 1'b0, 32'h0, 4'h0, h, wb, wa, wl, fa, rd);
        do_req(32'h3030, 1'b0, 32'h0, 4'h0, 5, 5, 1'b0);
        checks++; if (obs_unstable != 0 || obs_cycles != 14) begin errors++; $display("FAIL slow_evict unstable=%0d cycles=%0d exp=0/14", obs_unstable, obs_cycles); end
        checks++; if (obs_wdata_q.size() != 2 || obs_wdata_q[0] !== wl) begin errors++; $display("FAIL slow_evict_data txns=%0d exp=2", obs_wdata_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit h, wb, seen; logic [31:0] wa, fa, rd; logic [127:0] wl;
        @(negedge clk);
        cpu_addr = 32'h2050; cpu_rw = 1'b0; cpu_valid = 1'b1;
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_valid_o;
        end
        checks++; if (!seen) begin errors++; $display("FAIL midrst_alloc_seen got=0 exp=1"); end
        #1 rst_i = 1'b1;
        #1;
        checks++; if (mem_valid_o !== 1'b0 || cpu_ready_o !== 1'b0 || dbg_state_o !== ST_IDLE) begin
            errors++; $display("FAIL midrst_immediate valid=%b ready=%b state=%0d exp=0/0/0", mem_valid_o, cpu_ready_o, dbg_state_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (cpu_ready_o !== 1'b0 || mem_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_hold i=%0d ready=%b valid=%b exp=0/0", i, cpu_ready_o, mem_valid_o); end
        end
        rst_i = 1'b0;
        model_reset();
        model_access(32'h10, 1'b0, 32'h0, 4'h0, h, wb, wa, wl, fa, rd);
        do_req(32'h10, 1'b0, 32'h0, 4'h0, 0, 1, 1'b0);
        checks++; if (obs_addr_q.size() != 1 || obs_addr_q[0] !== 32'h10) begin errors++; $display("FAIL midrst_remiss txns=%0d exp=1 at 00000010", obs_addr_q.size()); end
        checks++; if (obs_rdata !== rd) begin errors++; $display("FAIL midrst_rdata got=%h exp=%h", obs_rdata, rd); end
    endtask

    task automatic test_random();
        bit h, wb; logic [31:0] wa, fa, rd, a, wd; logic [127:0] wl; logic rw; logic [3:0] be;
        int dw, df, nexp;
        for (int n = 0; n < 200; n++) begin
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            rw = 1'($urandom); wd = $urandom; be = 4'($urandom);
            dw = $urandom_range(0, 3); df = $urandom_range(0, 3);
            model_access(a, rw, wd, be, h, wb, wa, wl, fa, rd);
            do_req(a, rw, wd, be, dw, df, 1'($urandom));
            nexp = (h ? 0 : 1) + (wb ? 1 : 0);
            checks++; if (obs_timeout || obs_unstable != 0) begin errors++; $display("FAIL rand_protocol op=%0d timeout=%0d unstable=%0d exp=0/0", n, obs_timeout, obs_unstable); end
            checks++; if (obs_addr_q.size() != nexp) begin errors++; $display("FAIL rand_txns op=%0d addr=%h got=%0d exp=%0d", n, a, obs_addr_q.size(), nexp); end
            else if (nexp > 0) begin
                checks++; if (obs_addr_q[nexp-1] !== fa || obs_rw_q[nexp-1] !== 1'b0) begin errors++; $display("FAIL rand_fill op=%0d addr=%h exp=%h", n, obs_addr_q[nexp-1], fa); end
                if (wb) begin
                    checks++; if (obs_addr_q[0] !== wa || obs_rw_q[0] !== 1'b1 || obs_wdata_q[0] !== wl) begin
                        errors++; $display("FAIL rand_wb op=%0d addr=%h exp=%h data=%h exp=%h", n, obs_addr_q[0], wa, obs_wdata_q[0], wl); end
                end
            end
            checks++; if (obs_cycles != (h ? 1 : 3 + df + (wb ? 1 + dw : 0))) begin
                errors++; $display("FAIL rand_latency op=%0d got=%0d hit=%0d wb=%0d", n, obs_cycles, h, wb); end
            if (!rw) begin
                checks++; if (obs_rdata !== rd) begin errors++; $display("FAIL rand_rdata op=%0d addr=%h got=%h exp=%h", n, a, obs_rdata, rd); end
            end
        end
`ifdef DM_CACHE_STATS_EN
        checks++; if (hit_cnt_o !== 32'(model_hits) || miss_cnt_o !== 32'(model_misses)) begin
            errors++; $display("FAIL rand_stats hit=%0d miss=%0d exp=%0d/%0d", hit_cnt_o, miss_cnt_o, model_hits, model_misses); end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_cold_miss_hit();
        test_write_hit();
        test_dirty_evict();
        test_back_to_back();
        test_slow_mem();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
